// File: rtl/dcc_spi_sched.sv
// Round-robin scheduler for two requesters in front of the 112-bit SPI shift engine.
// Builds the packet, launches one transfer at a time, times out, and routes the read data back.
module dcc_spi_sched #(
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic         SSPCLK,
   input  logic         SSPRSTn,
   input  logic         REQ0_VALID,
   output logic         REQ0_READY,
   input  logic [7:0]   REQ0_CMD,
   input  logic [39:0]  REQ0_ADDR,
   input  logic [31:0]  REQ0_WDATA,
   input  logic         REQ1_VALID,
   output logic         REQ1_READY,
   input  logic [7:0]   REQ1_CMD,
   input  logic [39:0]  REQ1_ADDR,
   input  logic [31:0]  REQ1_WDATA,
   output logic         RSP0_VALID,
   output logic [31:0]  RSP0_RDATA,
   output logic         RSP0_ERR,
   output logic         RSP1_VALID,
   output logic [31:0]  RSP1_RDATA,
   output logic         RSP1_ERR,
   output logic         ENG_START,
   output logic [111:0] ENG_PKT,
   input  logic         ENG_DONE,
   input  logic [111:0] ENG_RXPKT,
   output logic         BUSY
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t       state, state_nxt;
   logic         last, owner, grant, err_q;
   logic [31:0]  rdata_q;
   logic [15:0]  cnt;
   logic [7:0]   cmd, gcmd;
   logic [39:0]  gaddr;
   logic [31:0]  gwdata;
   logic         legal, is_read, timeout, any_valid;

   // Command decode works off the registered packet so it is stable through ISSUE/WAIT.
   assign cmd       = ENG_PKT[111:104];
   assign legal     = cmd inside {8'h20, 8'hA0, 8'h40, 8'hC0};
   assign is_read   = (cmd == 8'h20) || (cmd == 8'h40);
   assign timeout   = (cnt == TO_LAST);
   assign any_valid = REQ0_VALID || REQ1_VALID;

   always_comb begin
      grant = REQ1_VALID;
      if (REQ0_VALID && REQ1_VALID) grant = ~last;
   end

   assign gcmd   = grant ? REQ1_CMD   : REQ0_CMD;
   assign gaddr  = grant ? REQ1_ADDR  : REQ0_ADDR;
   assign gwdata = grant ? REQ1_WDATA : REQ0_WDATA;

   always_ff @(posedge SSPCLK or negedge SSPRSTn) begin
      if (!SSPRSTn) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      REQ0_READY = 1'b0;
      REQ1_READY = 1'b0;
      ENG_START  = 1'b0;
      RSP0_VALID = 1'b0;
      RSP1_VALID = 1'b0;
      RSP0_RDATA = 32'h0;
      RSP1_RDATA = 32'h0;
      RSP0_ERR   = 1'b0;
      RSP1_ERR   = 1'b0;
      BUSY       = (state != IDLE);
      case (state)
         IDLE:  if (any_valid) state_nxt = ISSUE;
         ISSUE: begin
            REQ0_READY = ~owner;
            REQ1_READY = owner;
            ENG_START  = legal;
            state_nxt  = legal ? WAIT : RESP;
         end
         // DONE has priority over a coincident timeout.
         WAIT:  if (ENG_DONE || timeout) state_nxt = RESP;
         RESP: begin
            RSP0_VALID = ~owner;
            RSP1_VALID = owner;
            RSP0_RDATA = owner ? 32'h0 : rdata_q;
            RSP1_RDATA = owner ? rdata_q : 32'h0;
            RSP0_ERR   = ~owner & err_q;
            RSP1_ERR   = owner & err_q;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge SSPCLK or negedge SSPRSTn) begin
      if (!SSPRSTn) begin
         last    <= 1'b1;
         owner   <= 1'b0;
         ENG_PKT <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         cnt     <= '0;
      end else begin
         case (state)
            IDLE: if (any_valid) begin
               owner   <= grant;
               last    <= grant;
               ENG_PKT <= {gcmd, gaddr,
                           ((gcmd == 8'hA0) || (gcmd == 8'hC0)) ? gwdata : 32'h0,
                           32'h0};
            end
            ISSUE: begin
               cnt     <= '0;
               rdata_q <= '0;
               err_q   <= ~legal;
            end
            WAIT: begin
               cnt <= cnt + 16'd1;
               if (ENG_DONE) begin
                  rdata_q <= is_read ? ENG_RXPKT[31:0] : 32'h0;
                  err_q   <= 1'b0;
               end else if (timeout) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dcc_spi_sched.sv
// Scoreboard bench for dcc_spi_sched: stimulus queues expected grants/packets/responses,
// a negedge monitor pops and compares whenever the DUT presents READY, ENG_START or RSP.
module tb_dcc_spi_sched;

   logic         clk = 1'b0, rst_n = 1'b0;
   logic         REQ0_VALID, REQ1_VALID, REQ0_READY, REQ1_READY;
   logic [7:0]   REQ0_CMD, REQ1_CMD;
   logic [39:0]  REQ0_ADDR, REQ1_ADDR;
   logic [31:0]  REQ0_WDATA, REQ1_WDATA;
   logic         RSP0_VALID, RSP1_VALID, RSP0_ERR, RSP1_ERR;
   logic [31:0]  RSP0_RDATA, RSP1_RDATA;
   logic         ENG_START, ENG_DONE, BUSY;
   logic [111:0] ENG_PKT, ENG_RXPKT;

   dcc_spi_sched #(.TIMEOUT_CYCLES(8)) dut (
      .SSPCLK(clk), .SSPRSTn(rst_n),
      .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_CMD(REQ0_CMD),
      .REQ0_ADDR(REQ0_ADDR), .REQ0_WDATA(REQ0_WDATA),
      .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_CMD(REQ1_CMD),
      .REQ1_ADDR(REQ1_ADDR), .REQ1_WDATA(REQ1_WDATA),
      .RSP0_VALID(RSP0_VALID), .RSP0_RDATA(RSP0_RDATA), .RSP0_ERR(RSP0_ERR),
      .RSP1_VALID(RSP1_VALID), .RSP1_RDATA(RSP1_RDATA), .RSP1_ERR(RSP1_ERR),
      .ENG_START(ENG_START), .ENG_PKT(ENG_PKT), .ENG_DONE(ENG_DONE),
      .ENG_RXPKT(ENG_RXPKT), .BUSY(BUSY)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          port;
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   int           checks = 0, errors = 0, cyc = 0;
   int           last_start_cyc = 0, last_ready_cyc = 0, last_rsp_cyc = 0;
   bit           exp_grant[$];
   logic [111:0] exp_pkt[$];
   rsp_t         exp_rsp[$];
   int           start_log[$];
   bit           eng_auto = 0;
   logic [31:0]  eng_rx = '0;
   int           spur_req = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [111:0] act, input logic [111:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic miss(input string nm);
      checks++;
      errors++;
      $display("FAIL %s actual=event_or_timeout required=none", nm);
   endtask

   task automatic chk_quiet(input string nm);
      chk({nm, "_ctl"}, {REQ0_READY, REQ1_READY, RSP0_VALID, RSP0_ERR, RSP1_VALID,
                         RSP1_ERR, ENG_START, BUSY}, 0);
      chk({nm, "_data"}, {RSP0_RDATA, RSP1_RDATA}, 0);
      chk({nm, "_pkt"}, ENG_PKT, 0);
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      rsp_t e;
      if (rst_n) begin
         if (REQ0_READY || REQ1_READY) begin
            last_ready_cyc = cyc;
            if (exp_grant.size() == 0) miss("grant_unexpected");
            else chk("grant", {REQ1_READY, REQ0_READY}, exp_grant.pop_front() ? 2 : 1);
         end
         if (ENG_START) begin
            last_start_cyc = cyc;
            start_log.push_back(cyc);
            if (exp_pkt.size() == 0) miss("start_unexpected");
            else chk("eng_pkt", ENG_PKT, exp_pkt.pop_front());
         end
         if (RSP0_VALID || RSP1_VALID) begin
            last_rsp_cyc = cyc;
            if (exp_rsp.size() == 0) miss("rsp_unexpected");
            else begin
               e = exp_rsp.pop_front();
               chk("rsp_port", {RSP1_VALID, RSP0_VALID}, e.port ? 2 : 1);
               chk("rsp_rdata", e.port ? RSP1_RDATA : RSP0_RDATA, e.rdata);
               chk("rsp_err", e.port ? RSP1_ERR : RSP0_ERR, e.err);
               chk("rsp_other_quiet", e.port ? {RSP0_RDATA, RSP0_ERR} : {RSP1_RDATA, RSP1_ERR}, 0);
            end
         end
      end
   end

   // Engine model: auto-answers on the first WAIT cycle, or fires a stray DONE on request.
   initial begin
      int seen = 0;
      ENG_DONE  = 1'b0;
      ENG_RXPKT = '0;
      forever begin
         @(negedge clk);
         if ((eng_auto && ENG_START) || spur_req != seen) begin
            if (spur_req != seen) seen++;
            @(posedge clk); #1;
            ENG_DONE  = 1'b1;
            ENG_RXPKT = {80'hFFFF_FFFF_FFFF_FFFF_FFFF, eng_rx};
            @(posedge clk); #1;
            ENG_DONE  = 1'b0;
            ENG_RXPKT = '0;
         end
      end
   end

   task automatic set_req(input int n, input logic [7:0] c, input logic [39:0] a,
                          input logic [31:0] w);
      if (n == 0) begin
         REQ0_VALID = 1'b1; REQ0_CMD = c; REQ0_ADDR = a; REQ0_WDATA = w;
      end else begin
         REQ1_VALID = 1'b1; REQ1_CMD = c; REQ1_ADDR = a; REQ1_WDATA = w;
      end
   endtask

   task automatic wait_ready();
      bit got = 0;
      for (int k = 0; k < 100 && !got; k++) begin
         @(negedge clk);
         if (REQ0_READY || REQ1_READY) got = 1;
      end
      if (!got) miss("ready_timeout");
   endtask

   task automatic drive_req(input int n, input logic [7:0] c, input logic [39:0] a,
                            input logic [31:0] w);
      set_req(n, c, a, w);
      wait_ready();
      @(posedge clk); #1;
      if (n == 0) REQ0_VALID = 1'b0;
      else        REQ1_VALID = 1'b0;
   endtask

   task automatic drain();
      bit done = 0;
      for (int k = 0; k < 300 && !done; k++) begin
         @(negedge clk);
         if (exp_rsp.size() == 0) done = 1;
      end
      if (!done) miss("drain_timeout");
   endtask

   function automatic rsp_t mk(input bit p, input logic [31:0] d, input logic e);
      rsp_t r;
      r.port = p; r.rdata = d; r.err = e;
      return r;
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      REQ0_VALID = 0; REQ0_CMD = 0; REQ0_ADDR = 0; REQ0_WDATA = 0;
      REQ1_VALID = 0; REQ1_CMD = 0; REQ1_ADDR = 0; REQ1_WDATA = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_quiet("reset");
      @(posedge clk); #1 rst_n = 1'b1;

      // Write from requester 0: read-back data must be suppressed
      eng_auto = 1; eng_rx = 32'hDEAD_BEEF;
      exp_grant.push_back(0);
      exp_pkt.push_back(112'hA0_0000400004_AAAA5555_00000000);
      exp_rsp.push_back(mk(0, 32'h0, 0));
      drive_req(0, 8'hA0, 40'h00_0040_0004, 32'hAAAA_5555);
      drain();

      // Read from requester 1: data field zeroed, RX data returned
      eng_rx = 32'hAAAA_5555;
      exp_grant.push_back(1);
      exp_pkt.push_back(112'h20_0000400004_00000000_00000000);
      exp_rsp.push_back(mk(1, 32'hAAAA_5555, 0));
      drive_req(1, 8'h20, 40'h00_0040_0004, 32'hFFFF_FFFF);
      drain();

      // Contention: both held valid for four grants
      eng_rx = 32'hCAFE_0001;
      start_log.delete();
      for (int i = 0; i < 4; i++) begin
         exp_grant.push_back(i[0]);
         exp_pkt.push_back(i[0] ? 112'h20_0000000010_00000000_00000000
                                : 112'hA0_123456789A_0BADF00D_00000000);
         exp_rsp.push_back(i[0] ? mk(1, 32'hCAFE_0001, 0) : mk(0, 32'h0, 0));
      end
      set_req(0, 8'hA0, 40'h12_3456_789A, 32'h0BAD_F00D);
      set_req(1, 8'h20, 40'h00_0000_0010, 32'h7777_7777);
      repeat (4) wait_ready();
      @(posedge clk); #1 REQ0_VALID = 0; REQ1_VALID = 0;
      drain();
      chk("contention_starts", start_log.size(), 4);
      for (int i = 1; i < start_log.size(); i++)
         chk("start_to_start", start_log[i] - start_log[i-1], 4);

      // Timeout with TIMEOUT_CYCLES=8, then a stray DONE
      eng_auto = 0;
      exp_grant.push_back(0);
      exp_pkt.push_back(112'h40_FF00000001_00000000_00000000);
      exp_rsp.push_back(mk(0, 32'h0, 1));
      drive_req(0, 8'h40, 40'hFF_0000_0001, 32'h1111_1111);
      drain();
      chk("timeout_latency", last_rsp_cyc - last_start_cyc, 9);
      spur_req++;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("late_done_busy", BUSY, 0);
      end

      // Illegal command: no START, error response one cycle after READY
      eng_auto = 1; eng_rx = 32'h3333_3333;
      exp_grant.push_back(1);
      exp_rsp.push_back(mk(1, 32'h0, 1));
      drive_req(1, 8'h55, 40'h00_0000_0001, 32'h0000_0002);
      drain();
      chk("illegal_latency", last_rsp_cyc - last_ready_cyc, 1);

      exp_grant.push_back(1);
      exp_pkt.push_back(112'hC0_0000000100_5A5AA5A5_00000000);
      exp_rsp.push_back(mk(1, 32'h0, 0));
      drive_req(1, 8'hC0, 40'h00_0000_0100, 32'h5A5A_A5A5);
      drain();

      // Reset mid-WAIT: outputs clear without a clock, no response
      eng_auto = 0;
      exp_grant.push_back(0);
      exp_pkt.push_back(112'hA0_0000000200_00000001_00000000);
      drive_req(0, 8'hA0, 40'h00_0000_0200, 32'h0000_0001);
      repeat (3) @(negedge clk);
      chk("busy_before_reset", BUSY, 1);
      rst_n = 1'b0;
      #1;
      chk_quiet("async_reset");
      chk("pending_before_recovery", exp_grant.size() + exp_pkt.size() + exp_rsp.size(), 0);

      // Recovery contention: pointer back to 1, so requester 0 wins
      eng_auto = 1; eng_rx = 32'h1234_5678;
      exp_grant.push_back(0);
      exp_grant.push_back(1);
      exp_pkt.push_back(112'hA0_0000000300_00000300_00000000);
      exp_pkt.push_back(112'h40_0000000400_00000000_00000000);
      exp_rsp.push_back(mk(0, 32'h0, 0));
      exp_rsp.push_back(mk(1, 32'h1234_5678, 0));
      set_req(0, 8'hA0, 40'h00_0000_0300, 32'h0000_0300);
      set_req(1, 8'h40, 40'h00_0000_0400, 32'hFFFF_0000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) wait_ready();
      @(posedge clk); #1 REQ0_VALID = 0; REQ1_VALID = 0;
      drain();
      repeat (4) @(negedge clk);

      chk("grant_q_empty", exp_grant.size(), 0);
      chk("pkt_q_empty", exp_pkt.size(), 0);
      chk("rsp_q_empty", exp_rsp.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dcc_spi_sched.md
# dcc_spi_sched

Transaction scheduler in front of the 112-bit SPI shift engine to the FPGA. Arbitrates round-robin between two requesters (e.g. test agent and config loader) and builds the packet `Command[7:0] | Address[39:0] | DataIn[31:0] | DataOut[31:0]`. Launches one engine transfer at a time, enforces a completion timeout, and routes the captured 32-bit read data back to the requester that issued it.

## Interface
- `TIMEOUT_CYCLES`, 1023: max SSPCLK cycles spent waiting for `ENG_DONE`; legal range 2..65535.
- `SSPCLK` in 1: block clock, all logic on rising edge.
- `SSPRSTn` in 1: reset, asynchronous, active-low.
- `REQ0_VALID` / `REQ1_VALID` in 1: request pending; held with fields stable until READY.
- `REQ0_READY` / `REQ1_READY` out 1: one-cycle accept pulse.
- `REQ0_CMD` / `REQ1_CMD` in 8: command; legal 0x20 READ, 0xA0 WRITE, 0x40 CFG_READ, 0xC0 CFG_WRITE.
- `REQ0_ADDR` / `REQ1_ADDR` in 40: target address.
- `REQ0_WDATA` / `REQ1_WDATA` in 32: write data.
- `RSP0_VALID` / `RSP1_VALID` out 1: one-cycle response pulse.
- `RSP0_RDATA` / `RSP1_RDATA` out 32: read data, valid with RSPn_VALID.
- `RSP0_ERR` / `RSP1_ERR` out 1: timeout or illegal command, valid with RSPn_VALID.
- `ENG_START` out 1: one-cycle launch pulse to the shift engine.
- `ENG_PKT` out 112: packet to shift; registered, stable from START until next grant.
- `ENG_DONE` in 1: one-cycle completion pulse from the engine.
- `ENG_RXPKT` in 112: captured shifted-in packet; bits [31:0] = DataOut, valid with ENG_DONE.
- `BUSY` out 1: high whenever state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any REQn_VALID, pick grant, register owner, build ENG_PKT, go ISSUE. Otherwise stay.
- Arbitration: round-robin pointer `last`. With both valid, grant the requester != `last`. With one valid, grant it. `last` updates on every grant. Reset value `last`=1, so requester 0 wins first contention.
- Packet: `{CMD, ADDR, wfield, 32'h0}`. wfield = WDATA for 0xA0/0xC0, 32'h0 for 0x20/0x40.
- ISSUE (1 cycle): REQn_READY=1 for owner only.
  - Legal cmd: ENG_START=1, go WAIT.
  - Illegal cmd: no ENG_START; set err flag; go RESP.
- WAIT: timeout counter clears on entry and increments each cycle.
  - ENG_DONE=1: latch rdata = ENG_RXPKT[31:0] for reads, 32'h0 for writes; err=0; go RESP.
  - Else if counter == TIMEOUT_CYCLES-1: rdata=0, err=1, go RESP.
  - ENG_DONE and timeout in the same cycle: DONE wins.
- RESP (1 cycle): RSPn_VALID=1 for owner, RSPn_RDATA/RSPn_ERR driven from latches, go IDLE. Non-owner RSP outputs stay 0.
- ENG_DONE outside WAIT (late or spurious) is ignored: no state or output effect.
- Requester VALID dropping before READY is a protocol violation; the grant already taken still completes.

## Timing
- Reset: all outputs 0 (READY, RSP*, ENG_START, ENG_PKT, BUSY); state IDLE; counter 0; `last`=1.
- Reset mid-transaction aborts immediately, with no response. The engine shares SSPRSTn.
- VALID seen in IDLE at edge T:
  - ISSUE during T+1: READY, ENG_START, ENG_PKT valid, BUSY=1.
  - WAIT from T+2.
- ENG_DONE sampled at edge D: RESP during D+1, IDLE at D+2. Next grant is decided at D+2, and its START is at D+3.
- Minimum legal-cmd turnaround: START to START = 4 cycles when DONE comes on the first WAIT cycle.
- Illegal cmd: READY at T+1, RSP (ERR=1) at T+2.
- Timeout: WAIT lasts exactly TIMEOUT_CYCLES cycles; RSP with ERR=1 on the next cycle.

## Test plan
- Write: req0 {0xA0, 40'h0040_0004, 32'hAAAA_5555} -> ENG_PKT = 112'hA000_0040_0004_AAAA_5555_0000_0000, one START; DONE -> RSP0_VALID, RDATA=0, ERR=0.
- Read: req1 {0x20, 40'h0040_0004, 32'hFFFF_FFFF} -> ENG_PKT data field zero; DONE with RXPKT[31:0]=32'hAAAA_5555 -> RSP1_RDATA=32'hAAAA_5555, RSP0 silent.
- Contention: both valid continuously for 4 transactions -> grants 0,1,0,1; READY pulses alternate; no overlapping START.
- Timeout: TIMEOUT_CYCLES=8, no DONE -> RSP ERR=1 exactly 9 cycles after START.
  - Late DONE afterwards -> ignored, BUSY stays 0.
- Illegal cmd 0x55 -> no START, READY then RSP ERR=1 one cycle later.
  - Next legal request proceeds normally.
- Reset asserted mid-WAIT -> all outputs 0 asynchronously, no RSP.
  - After release, req0 and req1 both valid -> req0 granted first.
